// File: rtl/exe_div_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU) returning {remainder, quotient} as HI/LO.
// Optional macro DIV_EARLY_TERM_EN: finish immediately when |divisor| > |dividend|.
module exe_div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  cpu_clk_50M,
    input  logic                  cpu_rst,
    input  logic                  div_start,
    input  logic                  div_signed,
    input  logic [DATA_W-1:0]     div_opdata1,
    input  logic [DATA_W-1:0]     div_opdata2,
    input  logic                  div_cancel,
    output logic                  div_stall,
    output logic                  div_ready,
    output logic [2*DATA_W-1:0]   div_hilo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     rem_q, rem_d;
    logic [DATA_W-1:0]     quo_q, quo_d;
    logic [DATA_W-1:0]     dvs_q, dvs_d;
    logic                  q_neg_q, q_neg_d;
    logic                  r_neg_q, r_neg_d;
    logic [2*DATA_W-1:0]   hilo_q, hilo_d;

    logic                  a_neg, b_neg;
    logic [DATA_W-1:0]     a_mag, b_mag;
    logic [DATA_W:0]       r_shift, r_diff;
    logic                  r_ge;
    logic [DATA_W-1:0]     rem_nx, quo_nx;
    logic                  accept;

    assign a_neg = div_signed & div_opdata1[DATA_W-1];
    assign b_neg = div_signed & div_opdata2[DATA_W-1];
    assign a_mag = a_neg ? (~div_opdata1 + DATA_W'(1)) : div_opdata1;
    assign b_mag = b_neg ? (~div_opdata2 + DATA_W'(1)) : div_opdata2;

    // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder
    assign r_shift = {rem_q, quo_q[DATA_W-1]};
    assign r_diff  = r_shift - {1'b0, dvs_q};
    assign r_ge    = (r_shift >= {1'b0, dvs_q});
    assign rem_nx  = r_ge ? r_diff[DATA_W-1:0] : r_shift[DATA_W-1:0];
    assign quo_nx  = {quo_q[DATA_W-2:0], r_ge};

    assign accept  = (state_q == S_IDLE) & div_start & ~div_cancel;

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            hilo_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            hilo_q  <= hilo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        hilo_d  = hilo_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
                    dvs_d   = b_mag;
                    quo_d   = a_mag;
                    rem_d   = '0;
                    cnt_d   = '0;
                    if (div_opdata2 == '0) begin
                        state_d = S_DONE;
                        hilo_d  = {div_opdata1, {DATA_W{1'b1}}};
                    end
`ifdef DIV_EARLY_TERM_EN
                    else if (b_mag > a_mag) begin
                        state_d = S_DONE;
                        hilo_d  = {div_opdata1, {DATA_W{1'b0}}};
                    end
`endif
                    else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (div_cancel) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q + CNT_W'(1);
                    // result is registered on the way into DONE so it is valid with div_ready
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = S_DONE;
                        hilo_d  = {(r_neg_q ? (~rem_nx + DATA_W'(1)) : rem_nx),
                                   (q_neg_q ? (~quo_nx + DATA_W'(1)) : quo_nx)};
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign div_stall = ~cpu_rst & (accept | (state_q == S_CALC));
    assign div_ready = (state_q == S_DONE);
    assign div_hilo  = hilo_q;

endmodule

// File: tb/tb_exe_div_unit.sv
// Directed self-checking bench for exe_div_unit (DATA_W=32).
// Build with DIV_EARLY_TERM_EN defined to match the early-termination variant.
module tb_exe_div_unit;

    logic        cpu_clk_50M;
    logic        cpu_rst;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_opdata1;
    logic [31:0] div_opdata2;
    logic        div_cancel;
    logic        div_stall;
    logic        div_ready;
    logic [63:0] div_hilo;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef DIV_EARLY_TERM_EN
    localparam int SMALL_LAT = 1;
`else
    localparam int SMALL_LAT = 33;
`endif

    exe_div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst     (cpu_rst),
        .div_start   (div_start),
        .div_signed  (div_signed),
        .div_opdata1 (div_opdata1),
        .div_opdata2 (div_opdata2),
        .div_cancel  (div_cancel),
        .div_stall   (div_stall),
        .div_ready   (div_ready),
        .div_hilo    (div_hilo)
    );

    initial cpu_clk_50M = 1'b0;
    always #5 cpu_clk_50M = ~cpu_clk_50M;

    task automatic tick();
        @(posedge cpu_clk_50M);
        #1;
    endtask

    // Start one divide in the current cycle T and follow it to its ready pulse.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_hilo, input int exp_lat, input string name);
        int   lat;
        logic stall_ok;
        div_signed  = sgn;
        div_opdata1 = a;
        div_opdata2 = b;
        div_start   = 1'b1;
        #1;
        stall_ok = (div_stall === 1'b1);
        tick();
        div_start = 1'b0;
        #1;
        lat = 1;
        while (div_ready !== 1'b1 && lat < 45) begin
            if (div_stall !== 1'b1) stall_ok = 1'b0;
            tick();
            #1;
            lat++;
        end
        n_cmp++;
        if (lat !== exp_lat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        n_cmp++;
        if (stall_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL %s stall_while_busy: got 0 want 1", name);
        end
        n_cmp++;
        if (div_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL %s stall_in_done: got %b want 0", name, div_stall);
        end
        n_cmp++;
        if (div_hilo !== exp_hilo) begin
            n_bad++;
            $display("FAIL %s hilo: got %h want %h", name, div_hilo, exp_hilo);
        end
        tick();
        #1;
        n_cmp++;
        if (div_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s ready_pulse_width: got %b want 0", name, div_ready);
        end
    endtask

    task automatic test_reset();
        cpu_rst     = 1'b1;
        div_start   = 1'b1;
        div_signed  = 1'b0;
        div_opdata1 = 32'd100;
        div_opdata2 = 32'd7;
        div_cancel  = 1'b0;
        #2;
        n_cmp++;
        if (div_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL reset stall: got %b want 0", div_stall);
        end
        tick();
        tick();
        n_cmp++;
        if (div_ready !== 1'b0 || div_hilo !== 64'd0) begin
            n_bad++;
            $display("FAIL reset outputs: got ready=%b hilo=%h want ready=0 hilo=0", div_ready, div_hilo);
        end
        div_start = 1'b0;
        cpu_rst   = 1'b0;
        tick();
        #1;
        n_cmp++;
        if (div_ready !== 1'b0 || div_stall !== 1'b0 || div_hilo !== 64'd0) begin
            n_bad++;
            $display("FAIL reset release: got ready=%b stall=%b hilo=%h want 0 0 0", div_ready, div_stall, div_hilo);
        end
    endtask

    task automatic test_unsigned();
        do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, "divu_100_7");
        do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, SMALL_LAT, "divu_big_small");
    endtask

    task automatic test_signed();
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "div_m7_2");
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33, "div_7_m2");
        do_div(1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33, "div_m100_7");
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33, "div_overflow");
        do_div(1'b1, 32'hFFFF_FFFD, 32'd10, {32'hFFFF_FFFD, 32'd0}, SMALL_LAT, "div_m3_10");
    endtask

    task automatic test_div_zero();
        do_div(1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1, "divu_5_0");
        do_div(1'b1, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1, "div_m5_0");
    endtask

    task automatic test_cancel();
        logic [63:0] prev;
        int          seen;
        prev        = div_hilo;
        div_signed  = 1'b0;
        div_opdata1 = 32'd1000;
        div_opdata2 = 32'd3;
        div_start   = 1'b1;
        #1;
        tick();
        div_start = 1'b0;
        for (int k = 2; k <= 10; k++) tick();
        div_cancel = 1'b1;
        #1;
        n_cmp++;
        if (div_stall !== 1'b1) begin
            n_bad++;
            $display("FAIL cancel stall_before: got %b want 1", div_stall);
        end
        tick();
        div_cancel = 1'b0;
        #1;
        n_cmp++;
        if (div_stall !== 1'b0 || div_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL cancel idle_after: got stall=%b ready=%b want 0 0", div_stall, div_ready);
        end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (div_ready !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL cancel no_ready: got %0d pulses want 0", seen);
        end
        n_cmp++;
        if (div_hilo !== prev) begin
            n_bad++;
            $display("FAIL cancel hilo_kept: got %h want %h", div_hilo, prev);
        end
        div_start  = 1'b1;
        div_cancel = 1'b1;
        #1;
        n_cmp++;
        if (div_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL cancel idle_start: got stall=%b want 0", div_stall);
        end
        tick();
        div_start  = 1'b0;
        div_cancel = 1'b0;
        #1;
        n_cmp++;
        if (div_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL cancel idle_not_accepted: got stall=%b want 0", div_stall);
        end
        do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, "divu_9_3_after_cancel");
    endtask

    task automatic test_reset_mid_calc();
        int seen;
        div_signed  = 1'b0;
        div_opdata1 = 32'd100;
        div_opdata2 = 32'd7;
        div_start   = 1'b1;
        #1;
        tick();
        div_start = 1'b0;
        for (int k = 2; k <= 5; k++) tick();
        cpu_rst = 1'b1;
        #1;
        n_cmp++;
        if (div_stall !== 1'b0 || div_ready !== 1'b0 || div_hilo !== 64'd0) begin
            n_bad++;
            $display("FAIL rst_mid_calc outputs: got stall=%b ready=%b hilo=%h want 0 0 0", div_stall, div_ready, div_hilo);
        end
        tick();
        cpu_rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (div_ready !== 1'b0 || div_stall !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL rst_mid_calc quiet_after: got %0d active cycles want 0", seen);
        end
        do_div(1'b0, 32'd3, 32'd10, {32'd3, 32'd0}, SMALL_LAT, "divu_3_10");
    endtask

    task automatic test_back_to_back();
        do_div(1'b0, 32'hFFFF_FFFF, 32'd16, {32'h0000_000F, 32'h0FFF_FFFF}, 33, "b2b_first");
        do_div(1'b0, 32'd17, 32'd5, {32'd2, 32'd3}, 33, "b2b_second");
        do_div(1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1, "b2b_zero");
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_cancel();
        test_reset_mid_calc();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
